bus_arbiter_mux: RTL and testbench
==================================

Name: bus_arbiter_mux

Overview:
- Registered, parametrised successor to the datapath bus multiplexer.
- NUM_SRC sources each raise a request and present WIDTH-bit data. The block arbitrates between them and drives one registered bus value per cycle.
- Arbitration is fixed-priority or round-robin. The block supports multi-cycle locked ownership and detects and counts multi-driver conflicts.
- Sits between the register file / special registers (PC, HI, LO, Z, MDR, InPort, C) and all bus consumers. Replaces the implicit-latch priority chain with defined idle behaviour.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NUM_SRC, 24, number of sources; index 0 is highest fixed priority.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- HOLD_LAST, 1, 1 = bus holds the last value when idle, 0 = bus drives zero when idle.
- CNT_W, 16, width of the conflict counter.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- src_req  in  NUM_SRC  per-source request (the old RxOut/PCout/... enables).
- src_data  in  NUM_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- src_lock  in  1  while high, the current owner keeps the grant.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out came from a granted source this cycle.
- grant  out  NUM_SRC  registered one-hot grant vector; all zero when idle.
- grant_idx  out  clog2(NUM_SRC)  index of the current owner; 0 when idle.
- conflict  out  1  more than one src_req was high in the sampled cycle.
- conflict_count  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- All state updates on the rising clock edge.
- clear takes priority over every other input, including mid-lock. After clear: bus_out=0, bus_valid=0, grant=0, grant_idx=0, conflict=0, conflict_count=0, rr_ptr=0, state=IDLE.
- Latency: requests and data sampled at edge k appear on bus_out, grant and bus_valid after edge k. That is one cycle; there is no combinational path from inputs to outputs.
- State machine, states IDLE, OWN and LOCK:
  - IDLE: if any request is high, arbitrate and go to OWN; otherwise stay in IDLE.
  - OWN: if src_lock=1 and the owner's req=1, go to LOCK and keep the owner. Otherwise re-arbitrate every cycle: stay in OWN if any request is high, else go to IDLE.
  - LOCK: keep the owner while src_lock=1 and the owner's req=1. If the owner drops req, re-arbitrate immediately (go to OWN, or IDLE if no requests). If src_lock drops, go to OWN and re-arbitrate in that same cycle.
- Fixed priority (RR_MODE=0): the winner is the lowest index with req=1.
- Round-robin (RR_MODE=1): the winner is the first req=1 at or after rr_ptr, wrapping from NUM_SRC-1 to 0. On each new grant to index i, rr_ptr becomes (i+1) mod NUM_SRC. rr_ptr does not advance while in LOCK.
- Data path:
  - While a source is granted, bus_out captures that source's current src_data every cycle, including during LOCK.
  - When idle, bus_valid=0 and grant=0. bus_out holds its previous value if HOLD_LAST=1, or becomes 0 if HOLD_LAST=0.
- Conflict detection:
  - conflict is registered: it is 1 when popcount(src_req) > 1 in the sampled cycle, evaluated independently of lock.
  - conflict_count increments on each conflict cycle and saturates at 2^CNT_W-1 without wrapping.
- Invariant: grant is always one-hot or zero, and grant_idx always matches grant.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - source index constants: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23;
  - the state enum {IDLE, OWN, LOCK};
  - the default WIDTH and NUM_SRC.
- One sub-module, bus_arb_pick: a combinational picker that takes req, ptr and mode and returns a one-hot winner and its index. It is reused by later arbiters.

Test Plan:
- clear held 2 cycles, then req[20]=1 with data 0x0000_0100 → one cycle later bus_out=0x100, grant_idx=20, bus_valid=1, conflict=0.
- RR_MODE=0, req[3] and req[21] both high, data3=0xAAAA_0003 → bus_out=0xAAAA_0003, grant_idx=3, conflict=1, conflict_count=1.
- RR_MODE=1, requests 0, 5 and 23 held high for 4 cycles → grant_idx sequence 0, 5, 23, 0 (wrap-around); conflict_count=4.
- Owner 7 granted, then src_lock=1 for 3 cycles while req[2] is also high → grant stays 7 and bus_out follows data7 changes. src_lock drops → next cycle grant_idx=2.
- All requests drop after bus_out=0x1234_5678 → HOLD_LAST=1: bus_out stays 0x1234_5678 with bus_valid=0; HOLD_LAST=0: bus_out=0. clear asserted during LOCK → next cycle state=IDLE and all outputs 0.
- CNT_W=2, 5 consecutive conflict cycles → conflict_count sequence 1, 2, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared bus source indices, arbiter state encoding and default sizes.
package cpu_bus_pkg;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_SRC = 24;
   localparam int SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
   localparam int SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
   localparam int SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
   localparam int SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
   localparam int SRC_HI  = 16, SRC_LO  = 17, SRC_ZHI = 18, SRC_ZLO = 19;
   localparam int SRC_PC  = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_C = 23;
   typedef enum logic [1:0] {IDLE, OWN, LOCK} state_t;
endpackage

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: combinational winner picker; fixed priority from 0, or first request at/after i_ptr with wrap.
module bus_arb_pick #(
   parameter int N = 24
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   input  logic                 i_mode,
   output logic [N-1:0]         o_grant,
   output logic [$clog2(N)-1:0] o_idx,
   output logic                 o_any
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] w_base;
   logic [IW-1:0] w_pos [N];
   assign w_base = i_mode ? i_ptr : '0;
   for (genvar g = 0; g < N; g++) begin : g_pos
      assign w_pos[g] = IW'((32'(w_base) + g) % N);
   end
   // scan from the farthest offset down so the nearest request is assigned last
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[w_pos[i]]) begin
            o_idx = w_pos[i];
            o_any = 1'b1;
         end
      end
      o_grant = o_any ? (N'(1) << o_idx) : '0;
   end
endmodule

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered arbitrated bus multiplexer with lockable ownership
// and saturating multi-driver conflict counting.
module bus_arbiter_mux import cpu_bus_pkg::*; #(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_SRC   = DEF_NUM_SRC,
   parameter int RR_MODE   = 0,
   parameter int HOLD_LAST = 1,
   parameter int CNT_W     = 16
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic [NUM_SRC-1:0]         src_req,
   input  logic [NUM_SRC*WIDTH-1:0]   src_data,
   input  logic                       src_lock,
   output logic [WIDTH-1:0]           bus_out,
   output logic                       bus_valid,
   output logic [NUM_SRC-1:0]         grant,
   output logic [$clog2(NUM_SRC)-1:0] grant_idx,
   output logic                       conflict,
   output logic [CNT_W-1:0]           conflict_count
);
   localparam int IW = $clog2(NUM_SRC);
   state_t               r_state;
   logic [IW-1:0]        r_rr_ptr;
   logic [NUM_SRC-1:0]   w_pick_grant;
   logic [IW-1:0]        w_pick_idx;
   logic [IW-1:0]        w_idx;
   logic                 w_any;
   logic                 w_keep;
   logic                 w_valid;
   logic                 w_conflict;
   bus_arb_pick #(.N(NUM_SRC)) u_pick (
      .i_req   (src_req),
      .i_ptr   (r_rr_ptr),
      .i_mode  (RR_MODE != 0),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_any)
   );
   // the owner survives only while locked and still requesting; anything else re-arbitrates this cycle
   always_comb begin
      w_keep     = (r_state != IDLE) && src_lock && src_req[grant_idx];
      w_valid    = w_keep || w_any;
      w_idx      = w_keep ? grant_idx : w_pick_idx;
      w_conflict = |(src_req & (src_req - 1'b1));
   end
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state        <= IDLE;
         r_rr_ptr       <= '0;
         bus_out        <= '0;
         bus_valid      <= 1'b0;
         grant          <= '0;
         grant_idx      <= '0;
         conflict       <= 1'b0;
         conflict_count <= '0;
      end else begin
         r_state   <= w_keep ? LOCK : (w_any ? OWN : IDLE);
         grant     <= w_keep ? grant : w_pick_grant;
         grant_idx <= w_idx;
         bus_valid <= w_valid;
         bus_out   <= w_valid ? src_data[w_idx*WIDTH +: WIDTH] : ((HOLD_LAST != 0) ? bus_out : '0);
         if (!w_keep && w_any)
            r_rr_ptr <= (w_pick_idx == IW'(NUM_SRC - 1)) ? '0 : w_pick_idx + 1'b1;
         conflict <= w_conflict;
         if (w_conflict && conflict_count != '1)
            conflict_count <= conflict_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: directed vectors over four configurations sharing one stimulus.
module tb_bus_arbiter_mux;
   localparam int W = 32;
   localparam int N = 24;
   logic          clock = 1'b0;
   logic          clear;
   logic [N-1:0]  src_req;
   logic [N*W-1:0] src_data;
   logic          src_lock;
   logic [W-1:0] fp_bus, rr_bus, h0_bus, c2_bus;
   logic         fp_vld, rr_vld, h0_vld, c2_vld;
   logic [N-1:0] fp_gnt, rr_gnt, h0_gnt, c2_gnt;
   logic [4:0]   fp_idx, rr_idx, h0_idx, c2_idx;
   logic         fp_cf, rr_cf, h0_cf, c2_cf;
   logic [15:0]  fp_cnt, rr_cnt, h0_cnt;
   logic [1:0]   c2_cnt;
   int checks = 0;
   int errors = 0;
   always #5 clock = ~clock;
   bus_arbiter_mux #(.RR_MODE(0), .HOLD_LAST(1)) u_fp (.clock(clock), .clear(clear), .src_req(src_req),
      .src_data(src_data), .src_lock(src_lock), .bus_out(fp_bus), .bus_valid(fp_vld), .grant(fp_gnt),
      .grant_idx(fp_idx), .conflict(fp_cf), .conflict_count(fp_cnt));
   bus_arbiter_mux #(.RR_MODE(1), .HOLD_LAST(1)) u_rr (.clock(clock), .clear(clear), .src_req(src_req),
      .src_data(src_data), .src_lock(src_lock), .bus_out(rr_bus), .bus_valid(rr_vld), .grant(rr_gnt),
      .grant_idx(rr_idx), .conflict(rr_cf), .conflict_count(rr_cnt));
   bus_arbiter_mux #(.RR_MODE(0), .HOLD_LAST(0)) u_h0 (.clock(clock), .clear(clear), .src_req(src_req),
      .src_data(src_data), .src_lock(src_lock), .bus_out(h0_bus), .bus_valid(h0_vld), .grant(h0_gnt),
      .grant_idx(h0_idx), .conflict(h0_cf), .conflict_count(h0_cnt));
   bus_arbiter_mux #(.RR_MODE(0), .CNT_W(2)) u_c2 (.clock(clock), .clear(clear), .src_req(src_req),
      .src_data(src_data), .src_lock(src_lock), .bus_out(c2_bus), .bus_valid(c2_vld), .grant(c2_gnt),
      .grant_idx(c2_idx), .conflict(c2_cf), .conflict_count(c2_cnt));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic set_data(input int i, input logic [W-1:0] v);
      src_data[i*W +: W] = v;
   endtask
   task automatic check_fp_zero(input string tag);
      check({tag, " bus"}, fp_bus, 0);
      check({tag, " valid"}, fp_vld, 0);
      check({tag, " grant"}, fp_gnt, 0);
      check({tag, " idx"}, fp_idx, 0);
      check({tag, " conflict"}, fp_cf, 0);
      check({tag, " count"}, fp_cnt, 0);
   endtask
   initial begin
      logic [4:0] rr_exp [5];
      rr_exp = '{5'd0, 5'd5, 5'd23, 5'd0, 5'd5};
      clear = 1'b1;
      src_req = '0;
      src_lock = 1'b0;
      for (int i = 0; i < N; i++) set_data(i, 32'hD000_0000 | 32'(i));
      tick();
      tick();
      check_fp_zero("reset");
      clear = 1'b0;
      src_req[20] = 1'b1;
      set_data(20, 32'h0000_0100);
      tick();
      check("pc bus", fp_bus, 32'h100);
      check("pc idx", fp_idx, 20);
      check("pc grant", fp_gnt, 24'h10_0000);
      check("pc valid", fp_vld, 1);
      check("pc conflict", fp_cf, 0);
      src_req = '0;
      src_req[3] = 1'b1;
      src_req[21] = 1'b1;
      set_data(3, 32'hAAAA_0003);
      tick();
      check("fp bus", fp_bus, 32'hAAAA_0003);
      check("fp idx", fp_idx, 3);
      check("fp conflict", fp_cf, 1);
      check("fp count", fp_cnt, 1);
      check("rr after ptr 21", rr_idx, 21);
      clear = 1'b1;
      src_req = '0;
      tick();
      clear = 1'b0;
      src_req[0] = 1'b1;
      src_req[5] = 1'b1;
      src_req[23] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rr idx %0d", k), rr_idx, 64'(rr_exp[k]));
         check($sformatf("fp idx %0d", k), fp_idx, 0);
         check($sformatf("c2 count %0d", k), c2_cnt, (k < 3) ? k + 1 : 3);
         if (k == 3) check("rr count 4", rr_cnt, 4);
      end
      clear = 1'b1;
      src_req = '0;
      tick();
      clear = 1'b0;
      src_req[7] = 1'b1;
      set_data(7, 32'h0707_0001);
      tick();
      check("own7 idx", fp_idx, 7);
      src_req[2] = 1'b1;
      src_lock = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         set_data(7, 32'h0707_0000 | 32'(k));
         tick();
         check($sformatf("lock idx %0d", k), fp_idx, 7);
         check($sformatf("lock bus %0d", k), fp_bus, 32'h0707_0000 | 64'(k));
      end
      src_lock = 1'b0;
      tick();
      check("unlock idx", fp_idx, 2);
      check("unlock bus", fp_bus, 32'hD000_0002);
      src_req = '0;
      src_req[9] = 1'b1;
      set_data(9, 32'h1234_5678);
      tick();
      check("h1 bus", fp_bus, 32'h1234_5678);
      check("h0 bus", h0_bus, 32'h1234_5678);
      src_req = '0;
      tick();
      check("idle hold bus", fp_bus, 32'h1234_5678);
      check("idle valid", fp_vld, 0);
      check("idle grant", fp_gnt, 0);
      check("idle idx", fp_idx, 0);
      check("idle h0 bus", h0_bus, 0);
      src_req[4] = 1'b1;
      src_req[6] = 1'b1;
      tick();
      src_lock = 1'b1;
      tick();
      tick();
      check("lock4 idx", fp_idx, 4);
      clear = 1'b1;
      tick();
      check_fp_zero("clear in lock");
      clear = 1'b0;
      src_req = '0;
      src_req[4] = 1'b1;
      src_req[1] = 1'b1;
      tick();
      check("post clear arb", fp_idx, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
